// File: rtl/alu_decode_pkg.sv
// alu_decode_pkg
//   Shared definitions for the ALU decode stage: ALU control codes, RV32I
//   opcode constants, ALU A-operand select codes, the decoded-entry struct
//   carried across the ID/EX boundary, and the funct3 -> ALU code map used
//   by the register-register and register-immediate arithmetic groups.
package alu_decode_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  localparam logic [1:0] A_SEL_RS1  = 2'b00;
  localparam logic [1:0] A_SEL_PC   = 2'b01;
  localparam logic [1:0] A_SEL_ZERO = 2'b10;

  typedef struct packed {
    logic [3:0]  alu_ctl;
    logic [31:0] imm;
    logic        use_imm;
    logic [1:0]  a_sel;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        illegal;
  } decoded_t;

  // funct3 -> ALU code for the base (funct7 = 0) arithmetic encodings.
  function automatic logic [3:0] base_alu(input logic [2:0] funct3);
    logic [3:0] code;
    case (funct3)
      3'b000:  code = ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_decode_comb.sv
// alu_decode_comb
//   Purely combinational RV32I instruction decoder producing one decoded
//   entry (ALU code, immediate, operand selects, register indices, PC).
//   Unsupported encodings (unknown opcode or reserved funct fields) set
//   illegal and force a neutral ADD/rs1/zero-immediate entry.
// Ports:
//   instr  in   32  instruction word
//   pc     in   32  instruction PC, passed through into the entry
//   dec    out      decoded entry
module alu_decode_comb
  import alu_decode_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output decoded_t    dec
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] i_imm;
  logic [31:0] s_imm;
  logic [31:0] b_imm;
  logic [31:0] u_imm;
  logic [31:0] j_imm;
  logic [31:0] shamt_imm;
  logic        illegal;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];
  assign i_imm     = {{20{instr[31]}}, instr[31:20]};
  assign s_imm     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign b_imm     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign u_imm     = {instr[31:12], 12'b0};
  assign j_imm     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign shamt_imm = {27'b0, instr[24:20]};

  always_comb begin
    dec         = '0;
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.rd      = instr[11:7];
    dec.pc      = pc;
    dec.alu_ctl = ALU_ADD;
    dec.a_sel   = A_SEL_RS1;
    illegal     = 1'b0;

    case (opcode)
      OPC_OP: begin
        // The alternate funct7 only exists for SUB and SRA.
        if (funct7 == FUNCT7_BASE) begin
          dec.alu_ctl = base_alu(funct3);
        end else if (funct7 == FUNCT7_ALT && funct3 == 3'b000) begin
          dec.alu_ctl = ALU_SUB;
        end else if (funct7 == FUNCT7_ALT && funct3 == 3'b101) begin
          dec.alu_ctl = ALU_SRA;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec.use_imm = 1'b1;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          // Shifts: imm[11:5] acts as a funct7 and only SRAI may use ALT.
          dec.imm = shamt_imm;
          if (funct7 == FUNCT7_BASE) begin
            dec.alu_ctl = base_alu(funct3);
          end else if (funct7 == FUNCT7_ALT && funct3 == 3'b101) begin
            dec.alu_ctl = ALU_SRA;
          end else begin
            illegal = 1'b1;
          end
        end else begin
          dec.imm     = i_imm;
          dec.alu_ctl = base_alu(funct3);
        end
      end
      OPC_LOAD: begin
        dec.use_imm = 1'b1;
        dec.imm     = i_imm;
        // LB/LH/LW/LBU/LHU only.
        illegal     = (funct3 == 3'b011) || funct3[2:1] == 2'b11;
      end
      OPC_STORE: begin
        dec.use_imm = 1'b1;
        dec.imm     = s_imm;
        // SB/SH/SW only.
        illegal     = funct3[2] || (funct3 == 3'b011);
      end
      OPC_JALR: begin
        dec.use_imm = 1'b1;
        dec.imm     = i_imm;
        illegal     = (funct3 != 3'b000);
      end
      OPC_LUI: begin
        dec.use_imm = 1'b1;
        dec.imm     = u_imm;
        dec.a_sel   = A_SEL_ZERO;
      end
      OPC_AUIPC: begin
        dec.use_imm = 1'b1;
        dec.imm     = u_imm;
        dec.a_sel   = A_SEL_PC;
      end
      OPC_JAL: begin
        dec.use_imm = 1'b1;
        dec.imm     = j_imm;
        dec.a_sel   = A_SEL_PC;
      end
      OPC_BRANCH: begin
        // The ALU compares rs1/rs2; the B immediate rides along for the
        // branch target adder.
        dec.imm = b_imm;
        case (funct3[2:1])
          2'b00:   dec.alu_ctl = ALU_SUB;
          2'b10:   dec.alu_ctl = ALU_SLT;
          2'b11:   dec.alu_ctl = ALU_SLTU;
          default: illegal     = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      dec.alu_ctl = ALU_ADD;
      dec.use_imm = 1'b0;
      dec.imm     = '0;
      dec.a_sel   = A_SEL_RS1;
    end
    dec.illegal = illegal;
  end

endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage
//   ID/EX boundary: decodes one RV32I instruction per input transfer and
//   holds the decoded entry until the EX stage takes it.
//   Handshake: a transfer happens on a rising edge where valid & ready are
//   both high; the producer keeps valid and data stable until that edge,
//   ready may depend on state only (skid build) or on out_ready (default).
//   flush drops every held entry and any input offered in the same cycle.
// Build option:
//   ALU_DECODE_SKID_EN defined   -> 2-entry skid buffer, in_ready from a flop
//                                   (reset value RESET_IN_READY).
//   ALU_DECODE_SKID_EN undefined -> single output register,
//                                   in_ready = !out_valid | out_ready.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid/in_ready             input handshake
//   in_instr, in_pc               instruction word and PC
//   flush                         discard held and incoming entries
//   out_valid/out_ready           output handshake
//   out_alu_ctl, out_imm, out_use_imm, out_a_sel,
//   out_rs1, out_rs2, out_rd, out_pc, out_illegal   decoded entry
module alu_decode_stage
  import alu_decode_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter bit RESET_IN_READY = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_ctl,
  output logic [XLEN-1:0] out_imm,
  output logic            out_use_imm,
  output logic [1:0]      out_a_sel,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  decoded_t dec_entry;
  decoded_t head;
  logic     push;
  logic     pop;

  alu_decode_comb u_decode (
    .instr (in_instr),
    .pc    (in_pc),
    .dec   (dec_entry)
  );

`ifdef ALU_DECODE_SKID_EN
  decoded_t [1:0] mem_q, mem_d;
  logic           head_q, head_d;
  logic [1:0]     count_q, count_d;
  logic           ready_q, ready_d;

  assign in_ready  = ready_q;
  assign out_valid = (count_q != 2'd0);
  assign head      = mem_q[head_q];
  assign push      = in_valid & ready_q & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        head_d  = ~head_q;
        count_d = count_d - 2'd1;
      end
      // Tail slot is head+count; push is only possible with count < 2.
      if (push) begin
        mem_d[head_q ^ count_q[0]] = dec_entry;
        count_d = count_d + 2'd1;
      end
    end
    // Ready is computed from next occupancy so it can be registered.
    ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      head_q  <= 1'b0;
      count_q <= 2'd0;
      ready_q <= RESET_IN_READY;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end
`else
  decoded_t entry_q, entry_d;
  logic     valid_q, valid_d;
  logic     unused_reset_in_ready;

  // Ready is combinational here, so the reset value has no meaning.
  assign unused_reset_in_ready = RESET_IN_READY;

  assign in_ready  = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign head      = entry_q;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = valid_q & out_ready & ~flush;

  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (push) begin
      // Covers simultaneous drain: the new entry replaces the old one.
      entry_d = dec_entry;
      valid_d = 1'b1;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '0;
      valid_q <= 1'b0;
    end else begin
      entry_q <= entry_d;
      valid_q <= valid_d;
    end
  end
`endif

  assign out_alu_ctl = head.alu_ctl;
  assign out_imm     = head.imm;
  assign out_use_imm = head.use_imm;
  assign out_a_sel   = head.a_sel;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_rd      = head.rd;
  assign out_pc      = head.pc;
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage
//   Bench for alu_decode_stage: directed decode cases, backpressure,
//   flush and mid-stream reset, then randomized traffic against a
//   behavioural decode model and an in-order expected queue.
//   Honors ALU_DECODE_SKID_EN the same way as the design.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_alu_ctl;
  logic [31:0] out_imm;
  logic        out_use_imm;
  logic [1:0]  out_a_sel;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_pc;
  logic        out_illegal;

`ifdef ALU_DECODE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  alu_decode_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_alu_ctl (out_alu_ctl),
    .out_imm     (out_imm),
    .out_use_imm (out_use_imm),
    .out_a_sel   (out_a_sel),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_rd      (out_rd),
    .out_pc      (out_pc),
    .out_illegal (out_illegal)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0]  alu;
    logic [31:0] imm;
    logic        use_imm;
    logic [1:0]  a_sel;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        ill;
  } ref_t;
  localparam int EW = $bits(ref_t);

  // ALU code by funct3 for ADD,SLL,SLT,SLTU,XOR,SRL,OR,AND.
  localparam logic [3:0] OP_TAB [8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd2, 4'd3};
  localparam logic [6:0] OPS [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h67,
                                     7'h37, 7'h17, 7'h6F, 7'h63};

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [EW-1:0] model(input logic [31:0] ins, input logic [31:0] pc);
    ref_t r;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic ill;
    int i_v, s_v, b_v, j_v;
    op  = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    i_v = $signed(ins) >>> 20;
    s_v = (i_v & ~32'h1F) | int'(ins[11:7]);
    b_v = int'(ins[11:8]) * 2 + int'(ins[30:25]) * 32 + int'(ins[7]) * 2048
          - int'(ins[31]) * 4096;
    j_v = int'(ins[30:21]) * 2 + int'(ins[20]) * 2048 + int'(ins[19:12]) * 4096
          - int'(ins[31]) * (1 << 20);
    r = '0;
    r.rs1 = ins[19:15];
    r.rs2 = ins[24:20];
    r.rd  = ins[11:7];
    r.pc  = pc;
    ill = 1'b0;
    case (op)
      7'h33: begin
        if (f7 == 7'h00) r.alu = OP_TAB[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) r.alu = 4'd1;
        else if (f7 == 7'h20 && f3 == 3'd5) r.alu = 4'd9;
        else ill = 1'b1;
      end
      7'h13: begin
        r.use_imm = 1'b1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          r.imm = {27'd0, ins[24:20]};
          if (f7 == 7'h00) r.alu = OP_TAB[f3];
          else if (f7 == 7'h20 && f3 == 3'd5) r.alu = 4'd9;
          else ill = 1'b1;
        end else begin
          r.imm = i_v;
          r.alu = OP_TAB[f3];
        end
      end
      7'h03: begin r.use_imm = 1'b1; r.imm = i_v; ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); end
      7'h23: begin r.use_imm = 1'b1; r.imm = s_v; ill = !(f3 inside {3'd0, 3'd1, 3'd2}); end
      7'h67: begin r.use_imm = 1'b1; r.imm = i_v; ill = (f3 != 3'd0); end
      7'h37: begin r.use_imm = 1'b1; r.imm = ins & 32'hFFFFF000; r.a_sel = 2'd2; end
      7'h17: begin r.use_imm = 1'b1; r.imm = ins & 32'hFFFFF000; r.a_sel = 2'd1; end
      7'h6F: begin r.use_imm = 1'b1; r.imm = j_v; r.a_sel = 2'd1; end
      7'h63: begin
        r.imm = b_v;
        if (f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
        else if (f3 < 3'd2) r.alu = 4'd1;
        else if (f3 < 3'd6) r.alu = 4'd5;
        else r.alu = 4'd6;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      r.alu = 4'd0; r.use_imm = 1'b0; r.imm = '0; r.a_sel = 2'd0;
    end
    r.ill = ill;
    return r;
  endfunction

  function automatic logic [EW-1:0] obs_entry();
    return {out_alu_ctl, out_imm, out_use_imm, out_a_sel, out_rs1, out_rs2,
            out_rd, out_pc, out_illegal};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int r;
    w = $urandom;
    r = $urandom_range(0, 9);
    if (r < 9) w[6:0] = OPS[r];
    if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return w;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: check at negedge, update the expected queue at posedge,
  // return #1 after the edge so the caller can drive the next inputs.
  task automatic cycle(output logic accepted);
    logic exp_rdy, drn;
    @(negedge clk);
    if (CAP == 2) exp_rdy = (exp_q.size() < 2);
    else          exp_rdy = (exp_q.size() == 0) || out_ready;
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("entry", obs_entry(), exp_q[0]);
    accepted = in_valid & exp_rdy & ~flush;
    drn      = (exp_q.size() != 0) & out_ready & ~flush;
    @(posedge clk);
    if (flush) begin
      exp_q.delete();
    end else begin
      if (drn) void'(exp_q.pop_front());
      if (accepted) exp_q.push_back(model(in_instr, in_pc));
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic directed(input string tag, input logic [31:0] ins, input logic [3:0] alu,
                          input logic [31:0] imm, input logic use_imm,
                          input logic [1:0] a_sel, input logic ill);
    logic a;
    in_valid = 1'b1; in_instr = ins; in_pc = $urandom; out_ready = 1'b1; flush = 1'b0;
    cycle(a);
    in_valid = 1'b0;
    check({tag, ".valid"}, out_valid, 1'b1);
    check({tag, ".alu"}, out_alu_ctl, alu);
    check({tag, ".imm"}, out_imm, imm);
    check({tag, ".use_imm"}, out_use_imm, use_imm);
    check({tag, ".a_sel"}, out_a_sel, a_sel);
    check({tag, ".illegal"}, out_illegal, ill);
    cycle(a);
  endtask

  task automatic idle(input int n);
    logic a;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < n; i++) cycle(a);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic a;
    int k;

    // Reset state.
    #1;
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.in_ready", in_ready, 1'b1);
    check("rst.data", obs_entry(), '0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed decodes.
    directed("sub", 32'h40B50533, 4'b0001, 32'h0, 1'b0, 2'b00, 1'b0);
    directed("srai", 32'h40335293, 4'b1001, 32'h3, 1'b1, 2'b00, 1'b0);
    directed("addi", 32'hFFF00093, 4'b0000, 32'hFFFFFFFF, 1'b1, 2'b00, 1'b0);
    directed("lui", 32'h12345137, 4'b0000, 32'h12345000, 1'b1, 2'b10, 1'b0);
    directed("bltu", 32'h0020E463, 4'b0110, 32'h8, 1'b0, 2'b00, 1'b0);
    directed("ill_f7", 32'h02000033, 4'b0000, 32'h0, 1'b0, 2'b00, 1'b1);
    directed("ill_op", 32'h0000007F, 4'b0000, 32'h0, 1'b0, 2'b00, 1'b1);

    // Register indices of the SUB case.
    in_valid = 1'b1; in_instr = 32'h40B50533; in_pc = 32'h100;
    cycle(a);
    in_valid = 1'b0;
    check("sub.rs1", out_rs1, 5'd10);
    check("sub.rs2", out_rs2, 5'd11);
    check("sub.rd", out_rd, 5'd10);
    check("sub.pc", out_pc, 32'h100);
    idle(2);

    // Backpressure: 3 offers while out_ready=0 for 5 cycles.
    out_ready = 1'b0; k = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (k < 3);
      if (a || c == 0) begin in_instr = rand_instr(); in_pc = $urandom; end
      cycle(a);
      if (a) k++;
    end
    check("bp.in_ready", in_ready, 1'b0);
    check("bp.out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = (k < 3);
      if (a) begin in_instr = rand_instr(); in_pc = $urandom; end
      cycle(a);
      if (a) k++;
    end
    in_valid = 1'b0;
    check("bp.drained", out_valid, 1'b0);

    // Flush with held entries and a simultaneous offer.
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_instr = rand_instr(); in_pc = $urandom;
      cycle(a);
    end
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'hDEAD0000;
    cycle(a);
    flush = 1'b0; in_valid = 1'b0;
    check("flush.out_valid", out_valid, 1'b0);
    idle(3);

    // Reset mid-stream.
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00A00513; in_pc = 32'h44;
    cycle(a);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst.out_valid", out_valid, 1'b0);
    check("mrst.data", obs_entry(), '0);
    check("mrst.in_ready", in_ready, 1'b1);
    exp_q.delete();
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic.
    a = 1'b1;
    for (int c = 0; c < 800; c++) begin
      if (a || !in_valid) begin in_instr = rand_instr(); in_pc = $urandom; end
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 24) == 0);
      cycle(a);
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
